// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA constants for the program loader and the main decoder:
// mnemonic codes, opcode/funct literals, loader FSM states and field packers.
package mips_isa_pkg;

  localparam logic [4:0] MN_SLL  = 5'd0;
  localparam logic [4:0] MN_SRL  = 5'd1;
  localparam logic [4:0] MN_JR   = 5'd2;
  localparam logic [4:0] MN_MULT = 5'd3;
  localparam logic [4:0] MN_ADD  = 5'd4;
  localparam logic [4:0] MN_SUB  = 5'd5;
  localparam logic [4:0] MN_AND  = 5'd6;
  localparam logic [4:0] MN_OR   = 5'd7;
  localparam logic [4:0] MN_XOR  = 5'd8;
  localparam logic [4:0] MN_NOR  = 5'd9;
  localparam logic [4:0] MN_SLT  = 5'd10;
  localparam logic [4:0] MN_BEQ  = 5'd11;
  localparam logic [4:0] MN_BNE  = 5'd12;
  localparam logic [4:0] MN_BLT  = 5'd13;
  localparam logic [4:0] MN_BGT  = 5'd14;
  localparam logic [4:0] MN_ADDI = 5'd15;
  localparam logic [4:0] MN_SLTI = 5'd16;
  localparam logic [4:0] MN_ANDI = 5'd17;
  localparam logic [4:0] MN_ORI  = 5'd18;
  localparam logic [4:0] MN_XORI = 5'd19;
  localparam logic [4:0] MN_LW   = 5'd20;
  localparam logic [4:0] MN_SW   = 5'd21;
  localparam logic [4:0] MN_J    = 5'd22;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLT   = 6'h06;
  localparam logic [5:0] OP_BGT   = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_MULT = 6'h18;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_DONE
  } load_state_t;

  function automatic logic [31:0] enc_r(input logic [5:0] funct, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [4:0] shamt);
    return {OP_RTYPE, rs, rt, rd, shamt, funct};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] target);
    return {OP_J, target};
  endfunction

endpackage

// File: rtl/instr_loader_if.sv
// Symbolic-instruction stream plus instruction-memory write port of the loader.
// The loader sits on the slave side; the feeding bench or boot controller is the master.
interface instr_loader_if #(
  parameter int ADDR_W = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_mnem;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [4:0]        in_shamt;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              in_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              imem_ready;

  modport master (
    output in_valid, in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, in_last,
    output imem_ready,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, in_last,
    input  imem_ready,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_encoder.sv
// Combinational mnemonic-plus-fields to 32-bit MIPS word packer.
// Codes outside the instruction table come back with legal=0 and a zero word.
module instr_encoder
  import mips_isa_pkg::*;
(
  input  logic [4:0]  mnem,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        legal
);

  // Shifts ignore rs, jr keeps only rs, mult drops rd and shamt.
  always_comb begin
    word  = 32'h0;
    legal = 1'b1;
    case (mnem)
      MN_SLL:  word = enc_r(FN_SLL, 5'd0, rt, rd, shamt);
      MN_SRL:  word = enc_r(FN_SRL, 5'd0, rt, rd, shamt);
      MN_JR:   word = enc_r(FN_JR, rs, 5'd0, 5'd0, 5'd0);
      MN_MULT: word = enc_r(FN_MULT, rs, rt, 5'd0, 5'd0);
      MN_ADD:  word = enc_r(FN_ADD, rs, rt, rd, shamt);
      MN_SUB:  word = enc_r(FN_SUB, rs, rt, rd, shamt);
      MN_AND:  word = enc_r(FN_AND, rs, rt, rd, shamt);
      MN_OR:   word = enc_r(FN_OR, rs, rt, rd, shamt);
      MN_XOR:  word = enc_r(FN_XOR, rs, rt, rd, shamt);
      MN_NOR:  word = enc_r(FN_NOR, rs, rt, rd, shamt);
      MN_SLT:  word = enc_r(FN_SLT, rs, rt, rd, shamt);
      MN_BEQ:  word = enc_i(OP_BEQ, rs, rt, imm);
      MN_BNE:  word = enc_i(OP_BNE, rs, rt, imm);
      MN_BLT:  word = enc_i(OP_BLT, rs, rt, imm);
      MN_BGT:  word = enc_i(OP_BGT, rs, rt, imm);
      MN_ADDI: word = enc_i(OP_ADDI, rs, rt, imm);
      MN_SLTI: word = enc_i(OP_SLTI, rs, rt, imm);
      MN_ANDI: word = enc_i(OP_ANDI, rs, rt, imm);
      MN_ORI:  word = enc_i(OP_ORI, rs, rt, imm);
      MN_XORI: word = enc_i(OP_XORI, rs, rt, imm);
      MN_LW:   word = enc_i(OP_LW, rs, rt, imm);
      MN_SW:   word = enc_i(OP_SW, rs, rt, imm);
      MN_J:    word = enc_j(target);
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_loader.sv
// Program-load engine: encodes streamed symbolic instructions and writes them
// to consecutive instruction-memory words until the last one or capacity.
module instr_loader
  import mips_isa_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  instr_loader_if.slave     bus,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              full,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

  load_state_t       state;
  logic              last_q;
  logic [31:0]       enc_word;
  logic              enc_legal;
  logic [ADDR_W:0]   count_next;

  instr_encoder u_encoder (
    .mnem   (bus.in_mnem),
    .rs     (bus.in_rs),
    .rt     (bus.in_rt),
    .rd     (bus.in_rd),
    .shamt  (bus.in_shamt),
    .imm    (bus.in_imm),
    .target (bus.in_target),
    .word   (enc_word),
    .legal  (enc_legal)
  );

  assign count_next = count + 1'b1;

  // imem_addr doubles as the write pointer; all outputs are registered with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      last_q         <= 1'b0;
      bus.in_ready   <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= 32'h0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      full           <= 1'b0;
      count          <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state         <= ST_LOAD;
            bus.in_ready  <= 1'b1;
            bus.imem_addr <= '0;
            busy          <= 1'b1;
            done          <= 1'b0;
            err           <= 1'b0;
            full          <= 1'b0;
            count         <= '0;
          end
        end
        ST_LOAD: begin
          if (bus.in_valid) begin
            if (enc_legal) begin
              state          <= ST_WRITE;
              last_q         <= bus.in_last;
              bus.imem_wdata <= enc_word;
              bus.imem_we    <= 1'b1;
              bus.in_ready   <= 1'b0;
            end else begin
              err <= 1'b1;
              if (bus.in_last) begin
                state        <= ST_DONE;
                bus.in_ready <= 1'b0;
                busy         <= 1'b0;
                done         <= 1'b1;
              end
            end
          end
        end
        ST_WRITE: begin
          if (bus.imem_ready) begin
            bus.imem_we   <= 1'b0;
            bus.imem_addr <= bus.imem_addr + 1'b1;
            count         <= count_next;
            if (last_q || (count_next == CAPACITY)) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              full  <= (count_next == CAPACITY);
            end else begin
              state        <= ST_LOAD;
              bus.in_ready <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: directed scenarios plus random programs
// compared against an arithmetic encoding model and an expected write list.
module tb_instr_loader;

  typedef struct {
    logic [4:0]  mnem;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [25:0] target;
  } instr_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       start_b = 1'b0;
  logic       busy, done, err, full;
  logic [6:0] count;
  logic       busy_b, done_b, err_b, full_b;
  logic [2:0] count_b;

  int checks = 0;
  int failures = 0;
  bit ready_auto = 1'b0;
  bit stall_en = 1'b0;

  logic [5:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [1:0]  wr_addr_b[$];
  logic [31:0] wr_data_b[$];
  instr_t      prog[$];

  instr_loader_if #(.ADDR_W(6)) bus ();
  instr_loader_if #(.ADDR_W(2)) bus_b ();

  instr_loader #(.ADDR_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
    .busy(busy), .done(done), .err(err), .full(full), .count(count)
  );

  instr_loader #(.ADDR_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .bus(bus_b),
    .busy(busy_b), .done(done_b), .err(err_b), .full(full_b), .count(count_b)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  // Reference encoding built from the field layout with plain arithmetic.
  function automatic bit ref_encode(input instr_t ins, output logic [31:0] w);
    int unsigned funct_tab [11] = '{'h00, 'h02, 'h08, 'h18, 'h20, 'h22, 'h24, 'h25, 'h26, 'h27, 'h2A};
    int unsigned op_tab [11] = '{'h04, 'h05, 'h06, 'h07, 'h08, 'h0A, 'h0C, 'h0D, 'h0E, 'h23, 'h2B};
    int unsigned m, rs, rt, rd, sh;
    m = ins.mnem; rs = ins.rs; rt = ins.rt; rd = ins.rd; sh = ins.shamt;
    w = 32'h0;
    if (m <= 10) begin
      if (m <= 1) rs = 0;
      if (m == 2) begin rt = 0; rd = 0; sh = 0; end
      if (m == 3) begin rd = 0; sh = 0; end
      w = rs * 2097152 + rt * 65536 + rd * 2048 + sh * 64 + funct_tab[m];
      return 1'b1;
    end
    if (m <= 21) begin
      w = op_tab[m - 11] * 67108864 + rs * 2097152 + rt * 65536 + ins.imm;
      return 1'b1;
    end
    if (m == 22) begin
      w = 2 * 67108864 + ins.target;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic instr_t mk(input int mn, input int rs, input int rt, input int rd,
                                input int sh, input int imm, input int tgt);
    instr_t i;
    i.mnem = 5'(mn); i.rs = 5'(rs); i.rt = 5'(rt); i.rd = 5'(rd);
    i.shamt = 5'(sh); i.imm = 16'(imm); i.target = 26'(tgt);
    return i;
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    i = mk(0, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
    i.mnem = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(23, 31)) : 5'($urandom_range(0, 22));
    return i;
  endfunction

  task automatic pulseStart();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic sendInstr(input instr_t ins, input bit last, output bit ok);
    logic rdy;
    bus.in_mnem = ins.mnem; bus.in_rs = ins.rs; bus.in_rt = ins.rt; bus.in_rd = ins.rd;
    bus.in_shamt = ins.shamt; bus.in_imm = ins.imm; bus.in_target = ins.target;
    bus.in_last = last; bus.in_valid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      rdy = bus.in_ready;
      @(posedge clk); #1;
      if (rdy) ok = 1'b1;
    end
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
  endtask

  task automatic sendInstrB(input instr_t ins, input int limit, output bit ok);
    logic rdy;
    bus_b.in_mnem = ins.mnem; bus_b.in_rs = ins.rs; bus_b.in_rt = ins.rt; bus_b.in_rd = ins.rd;
    bus_b.in_shamt = ins.shamt; bus_b.in_imm = ins.imm; bus_b.in_target = ins.target;
    bus_b.in_last = 1'b0; bus_b.in_valid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < limit && !ok; c++) begin
      rdy = bus_b.in_ready;
      @(posedge clk); #1;
      if (rdy) ok = 1'b1;
    end
    bus_b.in_valid = 1'b0;
  endtask

  // Runs the program in prog and compares the written image and flags with the model.
  task automatic applyStimulus(input string tag, input bit stall);
    logic [31:0] exp_w[$];
    logic [31:0] w;
    bit          e_err;
    bit          ok;
    e_err = 1'b0;
    for (int i = 0; i < prog.size(); i++) begin
      if (ref_encode(prog[i], w)) exp_w.push_back(w);
      else e_err = 1'b1;
    end
    wr_addr_q.delete(); wr_data_q.delete();
    stall_en = stall; ready_auto = 1'b1;
    pulseStart();
    for (int i = 0; i < prog.size(); i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      sendInstr(prog[i], i == prog.size() - 1, ok);
      if (!ok) begin
        checkOutput({tag, "_accept_timeout"}, 64'(0), 64'(1));
        break;
      end
    end
    for (int c = 0; c < 600 && !done; c++) begin @(posedge clk); #1; end
    checkOutput({tag, "_done"}, 64'(done), 64'(1));
    checkOutput({tag, "_busy"}, 64'(busy), 64'(0));
    checkOutput({tag, "_in_ready"}, 64'(bus.in_ready), 64'(0));
    checkOutput({tag, "_count"}, 64'(count), 64'(exp_w.size()));
    checkOutput({tag, "_err"}, 64'(err), 64'(e_err));
    checkOutput({tag, "_full"}, 64'(full), 64'(0));
    checkOutput({tag, "_nwrites"}, 64'(wr_data_q.size()), 64'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < wr_data_q.size(); i++) begin
      checkOutput({tag, "_addr"}, 64'(wr_addr_q[i]), 64'(i));
      checkOutput({tag, "_data"}, 64'(wr_data_q[i]), 64'(exp_w[i]));
    end
  endtask

  initial begin
    bus.imem_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (ready_auto) bus.imem_ready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Write monitor: captures handshakes and checks the held-write protocol.
  initial begin
    bit          pend;
    logic [5:0]  paddr;
    logic [31:0] pdata;
    pend = 1'b0; paddr = '0; pdata = '0;
    forever begin
      @(posedge clk);
      if (rst_n && bus.imem_we) begin
        checkOutput("ready_while_we", 64'(bus.in_ready), 64'(0));
        if (pend) begin
          checkOutput("addr_stable", 64'(bus.imem_addr), 64'(paddr));
          checkOutput("data_stable", 64'(bus.imem_wdata), 64'(pdata));
        end
        if (bus.imem_ready) begin
          wr_addr_q.push_back(bus.imem_addr);
          wr_data_q.push_back(bus.imem_wdata);
          pend = 1'b0;
        end else begin
          pend = 1'b1; paddr = bus.imem_addr; pdata = bus.imem_wdata;
        end
      end else begin
        pend = 1'b0;
      end
      if (rst_n && bus_b.imem_we && bus_b.imem_ready) begin
        wr_addr_b.push_back(bus_b.imem_addr);
        wr_data_b.push_back(bus_b.imem_wdata);
      end
    end
  end

  initial begin
    bit          ok;
    int          accepts;
    logic [31:0] w;
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_mnem = '0; bus.in_rs = '0; bus.in_rt = '0;
    bus.in_rd = '0; bus.in_shamt = '0; bus.in_imm = '0; bus.in_target = '0;
    bus_b.in_valid = 1'b0; bus_b.in_last = 1'b0; bus_b.in_mnem = '0; bus_b.in_rs = '0;
    bus_b.in_rt = '0; bus_b.in_rd = '0; bus_b.in_shamt = '0; bus_b.in_imm = '0;
    bus_b.in_target = '0; bus_b.imem_ready = 1'b1;

    repeat (3) @(posedge clk); #1;
    checkOutput("rst_in_ready", 64'(bus.in_ready), 64'(0));
    checkOutput("rst_we", 64'(bus.imem_we), 64'(0));
    checkOutput("rst_addr", 64'(bus.imem_addr), 64'(0));
    checkOutput("rst_wdata", 64'(bus.imem_wdata), 64'(0));
    checkOutput("rst_flags", 64'({busy, done, err, full}), 64'(0));
    checkOutput("rst_count", 64'(count), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("idle_in_ready", 64'(bus.in_ready), 64'(0));
    checkOutput("idle_busy", 64'(busy), 64'(0));

    prog = '{mk(4, 1, 2, 3, 0, 0, 0), mk(15, 0, 8, 0, 0, 5, 0), mk(20, 8, 9, 0, 0, 4, 0)};
    applyStimulus("t1", 1'b0);
    if (wr_data_q.size() == 3) begin
      checkOutput("t1_w0", 64'(wr_data_q[0]), 64'h00221820);
      checkOutput("t1_w1", 64'(wr_data_q[1]), 64'h20080005);
      checkOutput("t1_w2", 64'(wr_data_q[2]), 64'h8D090004);
    end

    prog = '{mk(0, 7, 1, 2, 4, 0, 0), mk(22, 0, 0, 0, 0, 0, 'h10)};
    applyStimulus("t2", 1'b0);
    if (wr_data_q.size() == 2) begin
      checkOutput("t2_sll", 64'(wr_data_q[0]), 64'h00011100);
      checkOutput("t2_j", 64'(wr_data_q[1]), 64'h08000010);
    end

    ready_auto = 1'b0; bus.imem_ready = 1'b0;
    pulseStart();
    sendInstr(mk(11, 1, 2, 0, 0, 'hFFFF, 0), 1'b1, ok);
    checkOutput("t3_accept", 64'(ok), 64'(1));
    for (int c = 0; c < 4; c++) begin
      if (c == 3) bus.imem_ready = 1'b1;
      checkOutput("t3_we_held", 64'(bus.imem_we), 64'(1));
      checkOutput("t3_wdata", 64'(bus.imem_wdata), 64'h1022FFFF);
      checkOutput("t3_addr", 64'(bus.imem_addr), 64'(0));
      checkOutput("t3_in_ready", 64'(bus.in_ready), 64'(0));
      @(posedge clk); #1;
    end
    bus.imem_ready = 1'b0;
    checkOutput("t3_we_drop", 64'(bus.imem_we), 64'(0));
    checkOutput("t3_done", 64'(done), 64'(1));
    checkOutput("t3_count", 64'(count), 64'(1));

    prog = '{mk(25, 3, 4, 5, 6, 7, 8), mk(21, 0, 2, 0, 0, 0, 0)};
    applyStimulus("t4", 1'b0);
    checkOutput("t4_err", 64'(err), 64'(1));
    if (wr_data_q.size() == 1) begin
      checkOutput("t4_sw", 64'(wr_data_q[0]), 64'hAC020000);
      checkOutput("t4_addr", 64'(wr_addr_q[0]), 64'(0));
    end

    for (int r = 0; r < 8; r++) begin
      prog.delete();
      repeat ($urandom_range(1, 10)) prog.push_back(rand_instr());
      applyStimulus($sformatf("rnd%0d", r), r[0]);
    end

    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    accepts = 0;
    for (int k = 0; k < 5; k++) begin
      sendInstrB(mk(15, 0, k, 0, 0, k, 0), 20, ok);
      if (ok) accepts++;
    end
    checkOutput("cap_accepts", 64'(accepts), 64'(4));
    checkOutput("cap_full", 64'(full_b), 64'(1));
    checkOutput("cap_done", 64'(done_b), 64'(1));
    checkOutput("cap_count", 64'(count_b), 64'(4));
    checkOutput("cap_nwrites", 64'(wr_data_b.size()), 64'(4));
    for (int k = 0; k < 4 && k < wr_data_b.size(); k++) begin
      void'(ref_encode(mk(15, 0, k, 0, 0, k, 0), w));
      checkOutput("cap_addr", 64'(wr_addr_b[k]), 64'(k));
      checkOutput("cap_data", 64'(wr_data_b[k]), 64'(w));
    end

    ready_auto = 1'b0; bus.imem_ready = 1'b1;
    pulseStart();
    sendInstr(mk(4, 1, 1, 1, 0, 0, 0), 1'b0, ok);
    @(posedge clk); #1;
    bus.imem_ready = 1'b0;
    sendInstr(mk(5, 2, 2, 2, 0, 0, 0), 1'b1, ok);
    checkOutput("rstw_we_before", 64'(bus.imem_we), 64'(1));
    checkOutput("rstw_count_before", 64'(count), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rstw_we_async", 64'(bus.imem_we), 64'(0));
    checkOutput("rstw_count_async", 64'(count), 64'(0));
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("rstw_idle_ready", 64'(bus.in_ready), 64'(0));
    checkOutput("rstw_idle_flags", 64'({busy, done, err, full}), 64'(0));
    checkOutput("rstw_idle_count", 64'(count), 64'(0));
    checkOutput("rstw_idle_we", 64'(bus.imem_we), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
